// File: rtl/cacheline_mem_arbiter_if.sv
// Cacheline port bundle between the I-cache, D-cache and the memory/burst side.
// The arbiter takes the slave view; the surrounding caches and memory take the master view.
interface cacheline_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              icache_read_i;
    logic [ADDR_W-1:0] icache_addr_i;
    logic [LINE_W-1:0] icache_rdata_o;
    logic              icache_resp_o;

    logic              dcache_read_i;
    logic              dcache_write_i;
    logic [ADDR_W-1:0] dcache_addr_i;
    logic [LINE_W-1:0] dcache_wdata_i;
    logic [LINE_W-1:0] dcache_rdata_o;
    logic              dcache_resp_o;

    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_resp_i;

    modport slave (
        input  icache_read_i, icache_addr_i,
        input  dcache_read_i, dcache_write_i, dcache_addr_i, dcache_wdata_i,
        input  mem_rdata_i, mem_resp_i,
        output icache_rdata_o, icache_resp_o,
        output dcache_rdata_o, dcache_resp_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output icache_read_i, icache_addr_i,
        output dcache_read_i, dcache_write_i, dcache_addr_i, dcache_wdata_i,
        output mem_rdata_i, mem_resp_i,
        input  icache_rdata_o, icache_resp_o,
        input  dcache_rdata_o, dcache_resp_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Round-robin arbiter sharing one memory cacheline port between the I-cache and D-cache.
// One request is latched per grant and held on the memory port until mem_resp_i.
module cacheline_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    cacheline_mem_arbiter_if.slave bus
);
    localparam int OFS = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } side_t;

    state_t            state_q;
    state_t            state_d;
    side_t             last_grant_q;

    logic [ADDR_W-1:0] addr_p0;
    logic [LINE_W-1:0] wdata_p0;
    logic              op_rd_p0;
    logic              op_wr_p0;
    logic              vld_p0;

    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
        align_line = {addr[ADDR_W-1:OFS], {OFS{1'b0}}};
    endfunction

    assign i_req = bus.icache_read_i;
    assign d_req = bus.dcache_read_i | bus.dcache_write_i;

    // On a tie the side that was not served last wins; last_grant resets to I so D wins first.
    assign grant_d = (state_q == IDLE) && d_req && (!i_req || (last_grant_q == GNT_I));
    assign grant_i = (state_q == IDLE) && i_req && (!d_req || (last_grant_q == GNT_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                last_grant_q <= GNT_D;
            end else if (grant_i) begin
                last_grant_q <= GNT_I;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                end else if (grant_i) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant stage: request captured here stays frozen until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            op_rd_p0 <= 1'b0;
            op_wr_p0 <= 1'b0;
        end else if (grant_d) begin
            addr_p0  <= align_line(bus.dcache_addr_i);
            wdata_p0 <= bus.dcache_wdata_i;
            op_wr_p0 <= bus.dcache_write_i;
            op_rd_p0 <= ~bus.dcache_write_i;
        end else if (grant_i) begin
            addr_p0  <= align_line(bus.icache_addr_i);
            wdata_p0 <= bus.dcache_wdata_i;
            op_wr_p0 <= 1'b0;
            op_rd_p0 <= 1'b1;
        end
    end

    assign vld_p0 = (state_q == SERVE_I) || (state_q == SERVE_D);

    assign bus.mem_read_o  = vld_p0 & op_rd_p0;
    assign bus.mem_write_o = vld_p0 & op_wr_p0;
    assign bus.mem_addr_o  = addr_p0;
    assign bus.mem_wdata_o = wdata_p0;

    // Completion is routed in the same cycle as mem_resp_i; the DONE bubble follows.
    assign bus.icache_resp_o = ~rst & (state_q == SERVE_I) & bus.mem_resp_i;
    assign bus.dcache_resp_o = ~rst & (state_q == SERVE_D) & bus.mem_resp_i;

    assign bus.icache_rdata_o = rst ? '0 : bus.mem_rdata_i;
    assign bus.dcache_rdata_o = rst ? '0 : bus.mem_rdata_i;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Randomized scoreboard bench for cacheline_mem_arbiter: a transaction-level model predicts
// each memory command (side, op, aligned address, data, issue cycle); a monitor checks them.
module tb_cacheline_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int QD     = 1024;

    typedef struct {
        bit                side;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                cyc;
    } txn_t;

    typedef struct {
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cacheline_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cacheline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard FIFO: written by the stimulus process, read by the monitor.
    txn_t exp_mem [0:QD-1];
    int   wr_ptr;
    int   rd_ptr;

    // Stimulus/model state
    bit   out_i, out_d, gnt_i, gnt_d, busy, model_last, mem_pend;
    int   free_cyc, mem_cnt, mem_dly, p_i, p_d, drop_pct, spur_pct;
    int   seen_i_n, seen_d_n;
    bit   end_req, timed_out;
    req_t dir_i [$];
    req_t dir_d [$];

    // Monitor state
    int   n_vec, n_err, resp_cnt_i, resp_cnt_d;
    txn_t cur;
    bit   cur_valid, prev_cmd;
    logic [ADDR_W-1:0] last_addr;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on each new memory command.
    initial begin
        logic cmd, exp_i, exp_d;
        n_vec = 0; n_err = 0; resp_cnt_i = 0; resp_cnt_d = 0;
        rd_ptr = 0; cur_valid = 0; prev_cmd = 0; last_addr = '0;
        forever begin
            @(negedge clk);
            if (end_req) begin
                check("scoreboard_empty", 256'(wr_ptr - rd_ptr), 256'(0));
                check("no_timeout", 256'(timed_out), 256'(0));
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end else if (rst) begin
                check("reset_outputs",
                      256'({bus.mem_read_o, bus.mem_write_o, bus.icache_resp_o, bus.dcache_resp_o,
                            |bus.mem_addr_o, |bus.mem_wdata_o, |bus.icache_rdata_o, |bus.dcache_rdata_o}),
                      256'(0));
                rd_ptr = wr_ptr; cur_valid = 0; prev_cmd = 0; last_addr = '0;
            end else begin
                cmd = bus.mem_read_o | bus.mem_write_o;
                if (cmd && !prev_cmd) begin
                    if (rd_ptr == wr_ptr) begin
                        check("unexpected_cmd", 256'(1), 256'(0));
                        cur_valid = 0;
                    end else begin
                        cur = exp_mem[rd_ptr % QD];
                        rd_ptr++;
                        cur_valid = 1;
                        last_addr = cur.addr;
                        check("cmd_cycle", 256'(cyc), 256'(cur.cyc));
                    end
                end
                if (cmd && cur_valid) begin
                    check("mem_op", 256'({bus.mem_read_o, bus.mem_write_o}), 256'({~cur.wr, cur.wr}));
                    check("mem_addr", 256'(bus.mem_addr_o), 256'(cur.addr));
                    if (cur.wr) check("mem_wdata", bus.mem_wdata_o, cur.wdata);
                end
                if (!cmd) check("idle_addr", 256'(bus.mem_addr_o), 256'(last_addr));
                exp_i = cmd && cur_valid && bus.mem_resp_i && !cur.side;
                exp_d = cmd && cur_valid && bus.mem_resp_i && cur.side;
                check("resp", 256'({bus.icache_resp_o, bus.dcache_resp_o}), 256'({exp_i, exp_d}));
                if (cmd && bus.mem_resp_i) begin
                    check("icache_rdata", bus.icache_rdata_o, bus.mem_rdata_i);
                    check("dcache_rdata", bus.dcache_rdata_o, bus.mem_rdata_i);
                end
                if (bus.icache_resp_o) resp_cnt_i++;
                if (bus.dcache_resp_o) resp_cnt_d++;
                if (!cmd) cur_valid = 0;
                prev_cmd = cmd;
            end
        end
    end

    // One clock of stimulus: memory responder, both cache agents, then the arbitration model.
    task automatic step();
        logic cmd;
        req_t r;
        txn_t t;
        bit   ip, dp, side;
        @(posedge clk);
        #1;
        cmd = bus.mem_read_o | bus.mem_write_o;
        bus.mem_resp_i = 1'b0;
        if (!mem_pend && cmd) begin
            mem_pend = 1;
            mem_cnt  = (mem_dly < 0) ? int'($urandom_range(0, 4)) : mem_dly;
        end
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.mem_resp_i  = 1'b1;
                bus.mem_rdata_i = rand_line();
                mem_pend = 0;
                busy     = 0;
                free_cyc = cyc + 2;
            end else begin
                mem_cnt--;
            end
        end else if (int'($urandom_range(0, 99)) < spur_pct) begin
            bus.mem_resp_i  = 1'b1;
            bus.mem_rdata_i = rand_line();
        end

        if (resp_cnt_i != seen_i_n) begin
            seen_i_n = resp_cnt_i; out_i = 0; gnt_i = 0; bus.icache_read_i = 1'b0;
        end
        if (!out_i) begin
            if (dir_i.size() > 0 || int'($urandom_range(0, 99)) < p_i) begin
                if (dir_i.size() > 0) r = dir_i.pop_front();
                else r = '{rd: 1'b1, wr: 1'b0, addr: $urandom, wdata: '0};
                bus.icache_read_i = 1'b1;
                bus.icache_addr_i = r.addr;
                out_i = 1;
            end
        end else if (gnt_i && int'($urandom_range(0, 99)) < drop_pct) begin
            bus.icache_read_i = 1'b0;
            bus.icache_addr_i = $urandom;
        end

        if (resp_cnt_d != seen_d_n) begin
            seen_d_n = resp_cnt_d; out_d = 0; gnt_d = 0;
            bus.dcache_read_i = 1'b0; bus.dcache_write_i = 1'b0;
        end
        if (!out_d) begin
            if (dir_d.size() > 0 || int'($urandom_range(0, 99)) < p_d) begin
                if (dir_d.size() > 0) begin
                    r = dir_d.pop_front();
                end else begin
                    r.wr = 1'($urandom_range(0, 1));
                    r.rd = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
                    r.addr = $urandom;
                    r.wdata = rand_line();
                end
                bus.dcache_read_i  = r.rd;
                bus.dcache_write_i = r.wr;
                bus.dcache_addr_i  = r.addr;
                bus.dcache_wdata_i = r.wdata;
                out_d = 1;
            end
        end else if (gnt_d && int'($urandom_range(0, 99)) < drop_pct) begin
            bus.dcache_read_i  = 1'b0;
            bus.dcache_write_i = 1'b0;
            bus.dcache_addr_i  = $urandom;
            bus.dcache_wdata_i = rand_line();
        end

        // Arbitration rule: free one DONE cycle after a response; ties alternate.
        if (!busy && cyc >= free_cyc) begin
            ip = out_i && !gnt_i;
            dp = out_d && !gnt_d;
            if (ip || dp) begin
                side    = (ip && dp) ? ~model_last : dp;
                t.side  = side;
                t.wr    = side ? bus.dcache_write_i : 1'b0;
                t.addr  = (side ? bus.dcache_addr_i : bus.icache_addr_i) & ~32'h1f;
                t.wdata = bus.dcache_wdata_i;
                t.cyc   = cyc + 1;
                exp_mem[wr_ptr % QD] = t;
                wr_ptr++;
                busy = 1;
                model_last = side;
                if (side) gnt_d = 1;
                else gnt_i = 1;
            end
        end
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.icache_read_i = 1'b0; bus.dcache_read_i = 1'b0; bus.dcache_write_i = 1'b0;
        bus.mem_resp_i = 1'b0;
        out_i = 0; out_d = 0; gnt_i = 0; gnt_d = 0; busy = 0; mem_pend = 0; model_last = 0;
        dir_i.delete(); dir_d.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_i_n = resp_cnt_i; seen_d_n = resp_cnt_d;
        free_cyc = cyc;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(dir_i.size() == 0 && dir_d.size() == 0 && !out_i && !out_d && !busy) && n < budget);
        if (!(dir_i.size() == 0 && dir_d.size() == 0 && !out_i && !out_d && !busy)) timed_out = 1;
    endtask

    initial begin
        int start, n;
        rst = 1'b1;
        bus.icache_read_i = 1'b0; bus.icache_addr_i = '0;
        bus.dcache_read_i = 1'b0; bus.dcache_write_i = 1'b0;
        bus.dcache_addr_i = '0; bus.dcache_wdata_i = '0;
        bus.mem_resp_i = 1'b0; bus.mem_rdata_i = rand_line();
        wr_ptr = 0; end_req = 0; timed_out = 0;
        p_i = 0; p_d = 0; drop_pct = 0; spur_pct = 0; mem_dly = 0;
        seen_i_n = 0; seen_d_n = 0; mem_cnt = 0;
        apply_reset(3);

        // I-only read, memory answers three cycles after the command
        mem_dly = 3;
        dir_i.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1064, wdata: '0});
        run_until_idle(100);

        // D writeback of a patterned line
        mem_dly = 1;
        dir_d.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h8000_00A0, wdata: {8{32'hDEAD_BEEF}}});
        run_until_idle(100);

        // Both sides raised right after reset: D first, then I two cycles after its response
        apply_reset(2);
        mem_dly = 2;
        dir_i.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_2000, wdata: '0});
        dir_d.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_3000, wdata: '0});
        run_until_idle(100);

        // Continuous re-requesting from both sides for six transactions
        mem_dly = -1; p_i = 100; p_d = 100;
        start = wr_ptr; n = 0;
        while (wr_ptr - start < 6 && n < 200) begin step(); n++; end
        if (wr_ptr - start < 6) timed_out = 1;
        p_i = 0; p_d = 0;
        run_until_idle(100);

        // Reset in the middle of a D writeback
        mem_dly = 20;
        dir_d.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0440, wdata: rand_line()});
        n = 0;
        while (!bus.mem_write_o && n < 50) begin step(); n++; end
        if (!bus.mem_write_o) timed_out = 1;
        repeat (2) step();
        apply_reset(2);
        repeat (4) step();

        // Spurious memory responses in IDLE and DONE; D read+write together is a write
        spur_pct = 100; mem_dly = 2;
        repeat (3) step();
        dir_d.push_back('{rd: 1'b1, wr: 1'b1, addr: 32'h0000_5A7F, wdata: rand_line()});
        run_until_idle(100);
        repeat (3) step();
        dir_i.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_6010, wdata: '0});
        run_until_idle(100);
        spur_pct = 0;

        // Random traffic with drops, address jitter and spurious responses
        p_i = 30; p_d = 30; drop_pct = 15; spur_pct = 20; mem_dly = -1;
        repeat (2000) step();
        p_i = 0; p_d = 0;
        run_until_idle(200);
        repeat (3) step();

        end_req = 1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_not_reached: monitor did not finish");
        $fatal(1, "monitor did not finish");
    end
endmodule
